// File: rtl/vid_pattern_gen_if.sv
// Video output bus of the pattern generator: timing strobes plus one pixel per clock.
interface vid_pattern_gen_if #(
    parameter int unsigned DW = 8
);
    logic          O_de;
    logic          O_hs;
    logic          O_vs;
    logic          O_sof;
    logic [DW-1:0] O_data_r;
    logic [DW-1:0] O_data_g;
    logic [DW-1:0] O_data_b;

    modport master (
        output O_de, O_hs, O_vs, O_sof, O_data_r, O_data_g, O_data_b
    );

    modport slave (
        input  O_de, O_hs, O_vs, O_sof, O_data_r, O_data_g, O_data_b
    );
endinterface

// File: rtl/vid_pattern_gen.sv
// Programmable raster timing generator with built-in test patterns; every output
// leaves the block exactly PIPE clocks after the raster counter state that produced it.
module vid_pattern_gen #(
    parameter int unsigned DW   = 8,
    parameter int unsigned CW   = 12,
    parameter int unsigned PIPE = 5
) (
    input  logic            I_pxl_clk,
    input  logic            I_rst_n,
    input  logic [CW-1:0]   I_h_total,
    input  logic [CW-1:0]   I_h_sync,
    input  logic [CW-1:0]   I_h_bporch,
    input  logic [CW-1:0]   I_h_res,
    input  logic [CW-1:0]   I_v_total,
    input  logic [CW-1:0]   I_v_sync,
    input  logic [CW-1:0]   I_v_bporch,
    input  logic [CW-1:0]   I_v_res,
    input  logic            I_hs_pol,
    input  logic            I_vs_pol,
    input  logic [2:0]      I_mode,
    input  logic [3*DW-1:0] I_solid_rgb,
    vid_pattern_gen_if.master vid
);

    localparam int unsigned PW  = 3 * DW;
    localparam int unsigned NCT = PIPE - 1;
    localparam int unsigned NPX = PIPE - 2;

    typedef enum logic [2:0] {
        MODE_BARS  = 3'b000,
        MODE_GRID  = 3'b001,
        MODE_RAMP  = 3'b010,
        MODE_SOLID = 3'b011,
        MODE_CHECK = 3'b100
    } mode_e;

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;

    logic [CW-1:0] h_de_start;
    logic [CW-1:0] h_de_end;
    logic [CW-1:0] v_de_start;
    logic [CW-1:0] v_de_end;
    logic          de_raw;
    logic          hs_raw;
    logic          vs_raw;
    logic          sof_raw;

    logic [NCT-1:0] de_p;
    logic [NCT-1:0] hs_p;
    logic [NCT-1:0] vs_p;
    logic [NCT-1:0] sof_p;

    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;
    logic [CW-1:0] bar_pos_q;
    logic [2:0]    bar_idx_q;
    logic [CW-1:0] bar_w;
    logic [CW-1:0] bar_w_m1;
    mode_e         mode_q;
    logic [7:0]    frame_cnt;

    logic [CW-1:0] x_max;
    logic [CW-1:0] y_max;
    logic          grid_on;
    logic          check_on;
    logic [DW-1:0] pix_r;
    logic [DW-1:0] pix_g;
    logic [DW-1:0] pix_b;
    logic [PW-1:0] pix_p [NPX];

    logic          unused_c;

    // Raster counters; >= compares let a shrunk total wrap immediately.
    always_comb begin
        h_last = (h_cnt >= (I_h_total - CW'(1)));
        v_last = (v_cnt >= (I_v_total - CW'(1)));
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + CW'(1);
        end else begin
            h_cnt <= h_cnt + CW'(1);
        end
    end

    // Raw timing strobes, all window arithmetic truncated to CW bits.
    always_comb begin
        h_de_start = I_h_sync + I_h_bporch;
        h_de_end   = h_de_start + I_h_res - CW'(1);
        v_de_start = I_v_sync + I_v_bporch;
        v_de_end   = v_de_start + I_v_res - CW'(1);
        hs_raw     = (h_cnt < I_h_sync);
        vs_raw     = (v_cnt < I_v_sync);
        sof_raw    = (h_cnt == '0) && (v_cnt == '0);
        de_raw     = (h_cnt >= h_de_start) && (h_cnt <= h_de_end) &&
                     (v_cnt >= v_de_start) && (v_cnt <= v_de_end);
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            de_p  <= '0;
            hs_p  <= '0;
            vs_p  <= '0;
            sof_p <= '0;
        end else begin
            de_p  <= NCT'({de_p, de_raw});
            hs_p  <= NCT'({hs_p, hs_raw});
            vs_p  <= NCT'({vs_p, vs_raw});
            sof_p <= NCT'({sof_p, sof_raw});
        end
    end

    // Bar width is h_res/8 with a floor of one pixel.
    always_comb begin
        bar_w    = (I_h_res >> 3);
        if (bar_w == '0) begin
            bar_w = CW'(1);
        end
        bar_w_m1 = bar_w - CW'(1);
    end

    // Stage 1: pixel coordinates, incremental bar index, per-frame mode and frame count.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            bar_pos_q <= '0;
            bar_idx_q <= '0;
            mode_q    <= MODE_BARS;
            frame_cnt <= '0;
        end else begin
            if (de_raw && !de_p[0]) begin
                x_q       <= '0;
                bar_pos_q <= '0;
                bar_idx_q <= '0;
            end else if (de_raw) begin
                x_q <= x_q + CW'(1);
                if (bar_pos_q >= bar_w_m1) begin
                    bar_pos_q <= '0;
                    if (bar_idx_q != 3'd7) begin
                        bar_idx_q <= bar_idx_q + 3'd1;
                    end
                end else begin
                    bar_pos_q <= bar_pos_q + CW'(1);
                end
            end

            if (sof_raw) begin
                y_q <= '0;
            end else if (!de_raw && de_p[0]) begin
                y_q <= y_q + CW'(1);
            end

            if (sof_raw) begin
                mode_q <= mode_e'(I_mode);
            end

            // Counting on the wrap keeps the first frame after reset at 0.
            if (h_last && v_last) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Pattern generation from stage-1 state; blanked outside active video.
    always_comb begin
        x_max    = I_h_res - CW'(1);
        y_max    = I_v_res - CW'(1);
        grid_on  = (x_q[4:0] == 5'd0) || (y_q[4:0] == 5'd0) ||
                   (x_q == x_max) || (y_q == y_max);
        check_on = x_q[5] ^ y_q[5] ^ frame_cnt[0];
        pix_r    = '0;
        pix_g    = '0;
        pix_b    = '0;
        case (mode_q)
            MODE_BARS: begin
                pix_r = {DW{~bar_idx_q[1]}};
                pix_g = {DW{~bar_idx_q[2]}};
                pix_b = {DW{~bar_idx_q[0]}};
            end
            MODE_GRID: begin
                pix_r = {DW{grid_on}};
                pix_g = {DW{grid_on}};
                pix_b = {DW{grid_on}};
            end
            MODE_RAMP: begin
                pix_r = x_q[DW-1:0];
                pix_g = x_q[DW-1:0];
                pix_b = x_q[DW-1:0];
            end
            MODE_SOLID: begin
                pix_r = I_solid_rgb[DW-1:0];
                pix_g = I_solid_rgb[2*DW-1:DW];
                pix_b = I_solid_rgb[3*DW-1:2*DW];
            end
            MODE_CHECK: begin
                pix_r = {DW{check_on}};
                pix_g = {DW{check_on}};
                pix_b = {DW{check_on}};
            end
            default: begin
                pix_r = '0;
                pix_g = '0;
                pix_b = '0;
            end
        endcase
        if (!de_p[0]) begin
            pix_r = '0;
            pix_g = '0;
            pix_b = '0;
        end
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int unsigned i = 0; i < NPX; i++) begin
                pix_p[i] <= '0;
            end
        end else begin
            pix_p[0] <= {pix_b, pix_g, pix_r};
            for (int unsigned i = 1; i < NPX; i++) begin
                pix_p[i] <= pix_p[i-1];
            end
        end
    end

    // Output register; sync polarity applied here so reset shows the inactive level.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vid.O_de     <= 1'b0;
            vid.O_hs     <= ~I_hs_pol;
            vid.O_vs     <= ~I_vs_pol;
            vid.O_sof    <= 1'b0;
            vid.O_data_r <= '0;
            vid.O_data_g <= '0;
            vid.O_data_b <= '0;
        end else begin
            vid.O_de     <= de_p[NCT-1];
            vid.O_hs     <= hs_p[NCT-1] ? I_hs_pol : ~I_hs_pol;
            vid.O_vs     <= vs_p[NCT-1] ? I_vs_pol : ~I_vs_pol;
            vid.O_sof    <= sof_p[NCT-1];
            vid.O_data_r <= pix_p[NPX-1][DW-1:0];
            vid.O_data_g <= pix_p[NPX-1][2*DW-1:DW];
            vid.O_data_b <= pix_p[NPX-1][3*DW-1:2*DW];
        end
    end

    // Upper frame-count bits are kept for observability only.
    assign unused_c = ^frame_cnt[7:1];

endmodule

// File: doc/vid_pattern_gen.md
VID_PATTERN_GEN -- requirements
Module: vid_pattern_gen

Interface
REQ-001 Parameter DW, default 8, bits per colour channel (range 4..12).
REQ-002 Parameter CW, default 12, width of all timing inputs and internal counters.
REQ-003 Parameter PIPE, default 5, cycles from the raster counters to all outputs (range 3..8).
REQ-004 I_pxl_clk  in  1  pixel clock; the only clock in the block.
REQ-005 I_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 I_h_total, I_h_sync, I_h_bporch, I_h_res  in  CW each  horizontal timing, in pixels.
REQ-007 I_v_total, I_v_sync, I_v_bporch, I_v_res  in  CW each  vertical timing, in lines.
REQ-008 I_hs_pol, I_vs_pol  in  1 each  sync polarity; 1 = active-high pulse, 0 = active-low pulse.
REQ-009 I_mode  in  3  pattern select.
REQ-010 I_solid_rgb  in  3*DW  solid colour {b,g,r}.
REQ-011 O_de  out  1  active-video enable.
REQ-012 O_hs, O_vs  out  1 each  horizontal and vertical sync, polarity applied.
REQ-013 O_data_r, O_data_g, O_data_b  out  DW each  pixel colour.
REQ-014 O_sof  out  1  one-cycle start-of-frame pulse.

Function
REQ-015 H_cnt and V_cnt shall behave as follows: H_cnt counts 0..I_h_total-1; V_cnt increments when H_cnt >= I_h_total-1 and wraps to 0 when also V_cnt >= I_v_total-1 (>= compare, so a total shrunk mid-frame wraps on the next cycle).
REQ-016 Raw signals shall be: hs active while H_cnt < I_h_sync; vs active while V_cnt < I_v_sync; de while H_cnt is in [hs+hbp, hs+hbp+hres-1] and V_cnt is in [vs+vbp, vs+vbp+vres-1]; all arithmetic at CW bits.
REQ-017 O_de, O_hs, O_vs, O_sof and the pixel data shall all emerge exactly PIPE cycles after the counter state that produced them (mutually aligned, no skew).
REQ-018 Pixel coordinates x (0..I_h_res-1) and y (0..I_v_res-1) shall be derived from the raw de; x resets at each de rise; y resets on frame start and increments on each de fall.
REQ-019 The active mode register shall load I_mode only on the cycle where H_cnt==0 and V_cnt==0; a mid-frame change of I_mode has no visible effect until the next frame.
REQ-020 A frame counter, 8 bits, shall increment at each frame start and wrap 255->0.
REQ-021 Mode 000, colour bars: bar width = I_h_res>>3 (minimum 1); bar index = x / width, saturating at 7; order white, yellow, cyan, green, magenta, red, blue, black; full-scale = all ones at DW bits.
REQ-022 Mode 001, grid: white when x[4:0]==0 or y[4:0]==0 or x==I_h_res-1 or y==I_v_res-1, else black.
REQ-023 Mode 010, gray ramp: r=g=b=x[DW-1:0], wrapping every 2^DW pixels.
REQ-024 Mode 011, solid: output I_solid_rgb, sampled each pixel.
REQ-025 Mode 100, checker: white when x[5]^y[5]^frame_cnt[0] is 1, else black; the pattern inverts every frame.
REQ-026 Modes 101..111 shall output black.
REQ-027 Data shall be forced to 0 whenever O_de is 0.
REQ-028 O_sof shall be high for one cycle, aligned with the first cycle of the O_vs active level.
REQ-029 Polarity shall be applied at the output register: O_hs = raw_hs_active XNOR... i.e. O_hs equals I_hs_pol while hs is active and ~I_hs_pol otherwise; O_vs likewise with I_vs_pol.

Reset
REQ-030 While I_rst_n=0: all counters, the pipeline and the frame counter are 0; O_de=0, O_sof=0, data=0; O_hs=~I_hs_pol and O_vs=~I_vs_pol (inactive level); the mode register is 000.
REQ-031 Reset asserted mid-frame shall clear state immediately; after deassertion the raster restarts at H_cnt=0, V_cnt=0, and the first O_sof appears PIPE cycles after the first clock edge.

Verification
REQ-032 Timing set ht=20 hs=2 hbp=3 hres=8, vt=10 vs=1 vbp=2 vres=4, PIPE=5, pols=0 -> O_de high for 8 cycles per line on 4 lines/frame; first O_de rises at cycle 3*20+5+5 after reset release; O_hs low for 2 of every 20 cycles.
REQ-033 Same timing, mode 000, DW=8 -> the 8 pixels of each line are FFFFFF, 00FFFF, FFFF00, 00FF00, FF00FF, 0000FF, FF0000, 000000 ({b,g,r}).
REQ-034 Mode 100 over 3 frames -> the pixel at (0,0) is black, white, black; O_sof pulses exactly once per 200 cycles.
REQ-035 I_mode changed 000->010 mid-frame -> bars continue until frame end; the next frame shows ramp values 0..7.
REQ-036 pols=1 -> O_hs/O_vs are active-high; reset pulsed mid-line -> all outputs take their reset values asynchronously, and the raster restarts per REQ-031.
REQ-037 I_h_total reduced 20->16 mid-line with H_cnt=18 -> H_cnt wraps to 0 on the next cycle; no lockup.
